pattern_tx: RTL and testbench

Serial pattern transmitter: the drive side for the team's serial sequence detectors.
- Captures a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable run of idle-zero cycles between repetitions.
- Used as the bit source for detector benches and as an on-chip test-pattern generator feeding a detector's serial input.

---
 rtl/pattern_tx_pkg.sv | 14 +
 rtl/pattern_tx_if.sv | 28 ++
 rtl/pattern_tx_piso_shreg.sv | 38 +++
 rtl/pattern_tx.sv | 151 +++++++++++++++
 tb/tb_pattern_tx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and
// the default detector test pattern.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Reference pattern used to exercise the 1010 sequence detectors.
  localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage

// File: rtl/pattern_tx_if.sv
// Request/stream bundle between a pattern source controller (master) and
// the transmitter (slave).
interface pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, gap,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps, gap,
    output out, out_valid, busy, done
  );

endinterface

// File: rtl/pattern_tx_piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first; zeros shift in at the
// LSB so a fully shifted-out register reads back as 0.
module piso_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg_reg;
  logic [W-1:0] shreg_next;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shreg_next[gi] = load ? din[gi] : (shift ? 1'b0 : shreg_reg[gi]);
      end else begin : g_upper
        assign shreg_next[gi] = load ? din[gi] : (shift ? shreg_reg[gi-1] : shreg_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= shreg_next;
    end
  end

  assign msb = shreg_reg[W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first a
// programmable number of times with programmable idle gaps between copies.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  pattern_tx_if.slave  bus
);

  localparam int BIT_W = $clog2(PAT_W);

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [CNT_W-1:0] rep_cnt_reg;
  logic [GAP_W-1:0] gap_len_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             last_bit;
  logic             accept;
  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_msb;

  assign last_bit = (bit_cnt_reg == BIT_W'(PAT_W - 1));
  assign accept   = bus.start && (bus.reps != '0);

  // Shift-register control. Shifting past the LSB leaves the register all
  // zero, which is what keeps out low during GAP and IDLE.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = pat_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          sh_load = 1'b1;
          sh_din  = bus.pattern;
        end
      end
      SEND: begin
        if (last_bit && (rep_cnt_reg != CNT_W'(1)) && (gap_len_reg == '0)) begin
          sh_load = 1'b1;
        end else begin
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        sh_load = (gap_cnt_reg == GAP_W'(1));
      end
      default: begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
      end
    endcase
  end

  piso_shreg #(
    .W (PAT_W)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pat_reg     <= '0;
      rep_cnt_reg <= '0;
      gap_len_reg <= '0;
      gap_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            pat_reg     <= bus.pattern;
            rep_cnt_reg <= bus.reps;
            gap_len_reg <= bus.gap;
            bit_cnt_reg <= '0;
            valid_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= SEND;
          end else if (bus.start) begin
            // Zero repetitions: nothing to send, acknowledge at once.
            done_reg <= 1'b1;
          end
        end

        SEND: begin
          if (!last_bit) begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
          end else begin
            bit_cnt_reg <= '0;
            if (rep_cnt_reg != CNT_W'(1)) begin
              rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
              if (gap_len_reg != '0) begin
                gap_cnt_reg <= gap_len_reg;
                valid_reg   <= 1'b0;
                state_reg   <= GAP;
              end
            end else begin
              rep_cnt_reg <= '0;
              valid_reg   <= 1'b0;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= IDLE;
            end
          end
        end

        GAP: begin
          if (gap_cnt_reg == GAP_W'(1)) begin
            gap_cnt_reg <= '0;
            valid_reg   <= 1'b1;
            state_reg   <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.out       = sh_msb;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: a cycle-stamped reference stream is
// queued per accepted request and checked by an independent monitor.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit is_done;
    bit val;
    bit last;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   free_from = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  bit   det_en = 1'b0;
  int   det_cnt = 0;
  logic [3:0] hist = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Reference: request accepted at edge t produces bits at cycles t.., gaps
  // of g zero cycles between copies, and done right after the last bit.
  task automatic model_accept(input logic [PAT_W-1:0] p, input int r, input int g, input int t);
    int k;
    k = t;
    for (int rep = 0; rep < r; rep++) begin
      for (int i = 0; i < PAT_W; i++) begin
        exp_q.push_back('{is_done: 1'b0, val: p[PAT_W-1-i], last: (i == PAT_W-1), cyc: k});
        k++;
      end
      if (rep < r - 1) k += g;
    end
    exp_q.push_back('{is_done: 1'b1, val: 1'b0, last: 1'b0, cyc: k});
    if (r != 0) begin
      busy_lo = t;
      busy_hi = k - 1;
    end
    free_from = k + 1;
  endtask

  // Called just after a rising edge; start is seen by the next edge.
  task automatic issue(input logic [PAT_W-1:0] p, input int r, input int g);
    int t;
    t = cyc + 1;
    bus.start   = 1'b1;
    bus.pattern = p;
    bus.reps    = CNT_W'(r);
    bus.gap     = GAP_W'(g);
    $display("req t=%0d pattern=%b reps=%0d gap=%0d %s", t, p, r, g,
             (t >= free_from) ? "accepted" : "ignored");
    if (t >= free_from) model_accept(p, r, g, t);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.pattern = PAT_W'($urandom);
    bus.reps    = CNT_W'($urandom);
    bus.gap     = GAP_W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    free_from = cyc + 1;
    chk("rst_out", bus.out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    $display("reset at cyc=%0d", cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit or done.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t h;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk(exp_q[0].is_done ? "missing_done" : "missing_bit", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
      hist = {hist[2:0], bus.out};
      if (det_en && hist == PAT_1010) det_cnt++;
      if (bus.out_valid === 1'b1) begin
        chk("bit_expected", (exp_q.size() > 0 && !exp_q[0].is_done), 1);
        if (exp_q.size() > 0 && !exp_q[0].is_done) begin
          h = exp_q.pop_front();
          chk("bit_value", bus.out, h.val);
          chk("bit_cycle", cyc, h.cyc);
          if (det_en && hist == PAT_1010) chk("det_on_last_bit", h.last, 1);
        end
      end else begin
        chk("idle_out_zero", bus.out, 0);
      end
      if (bus.done === 1'b1) begin
        chk("done_expected", (exp_q.size() > 0 && exp_q[0].is_done), 1);
        if (exp_q.size() > 0 && exp_q[0].is_done) begin
          h = exp_q.pop_front();
          chk("done_cycle", cyc, h.cyc);
          $display("done at cyc=%0d", cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;
    bus.gap     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("init_out", bus.out, 0);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_done", bus.done, 0);
    free_from = cyc + 1;
    mon_en = 1'b1;

    // Single copy, gapped copies, back-to-back copies, empty request.
    issue(PAT_1010, 1, 0); wait_cyc(free_from);
    issue(PAT_1010, 3, 2); wait_cyc(free_from);
    issue(PAT_1010, 2, 0); wait_cyc(free_from);
    issue(4'b0110, 0, 3);  wait_cyc(free_from);

    // Start during the 2nd bit is ignored; start in the done cycle is taken.
    issue(PAT_1010, 1, 0);
    idle(1);
    issue(4'b1111, 1, 0);
    wait_cyc(free_from - 1);
    issue(4'b1100, 2, 1);
    wait_cyc(free_from);

    // Reset during the 3rd bit, then a clean transfer.
    issue(PAT_1010, 2, 0);
    idle(2);
    do_reset();
    issue(PAT_1010, 1, 0); wait_cyc(free_from + 1);

    // Loopback into a 1010 detector.
    det_cnt = 0;
    det_en  = 1'b1;
    issue(PAT_1010, 5, 1);
    wait_cyc(free_from + 1);
    det_en = 1'b0;
    chk("det_count", det_cnt, 5);

    // Randomized traffic, including starts that land while busy.
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 6));
      issue(PAT_W'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
    end
    t0 = free_from + 2;
    wait_cyc(t0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
